// File: rtl/dmem_bridge.sv
// dmem_bridge: converts M-stage load/store requests into a two-phase
// (address-accept, data-complete) bus handshake. The pipeline is frozen with
// stallM while an access is outstanding. A saturating wait counter aborts
// accesses that take too long and raises a sticky bus_err flag.
module dmem_bridge #(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        memreadM,
   input  logic [3:0]  memwriteM,
   input  logic [31:0] aluoutM,
   input  logic [31:0] writedataM,
   output logic [31:0] readdataM,
   output logic        stallM,
   output logic        data_req,
   output logic        data_wr,
   output logic [3:0]  data_wstrb,
   output logic [31:0] data_addr,
   output logic [31:0] data_wdata,
   input  logic        data_addr_ok,
   input  logic        data_data_ok,
   input  logic [31:0] data_rdata,
   output logic        bus_err
);

   // Counter is wide enough to hold MAX_WAIT itself; it saturates there.
   localparam int unsigned CW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_is_read;

   logic          w_access;
   logic          w_store;
   logic [CW-1:0] w_cnt_inc;
   logic          w_cnt_hit;

   // A store wins over a load when both are requested.
   assign w_access  = memreadM | (memwriteM != 4'd0);
   assign w_store   = (memwriteM != 4'd0);
   // Saturating increment; the timeout fires when this cycle brings the count to MAX_WAIT.
   assign w_cnt_inc = (r_cnt == MAX_CNT) ? r_cnt : (r_cnt + CW'(1'b1));
   assign w_cnt_hit = (w_cnt_inc == MAX_CNT);

   // Pipeline freeze: asserted as soon as an access shows up in IDLE, released in DONE.
   always_comb begin
      stallM = 1'b0;
      case (r_state)
         S_IDLE:  stallM = w_access;
         S_REQ:   stallM = 1'b1;
         S_WAIT:  stallM = 1'b1;
         S_DONE:  stallM = 1'b0;
         default: stallM = 1'b0;
      endcase
   end

   // Bridge FSM with registered bus outputs, wait counter, load data and error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_is_read  <= 1'b0;
         readdataM  <= 32'd0;
         bus_err    <= 1'b0;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_wstrb <= 4'd0;
         data_addr  <= 32'd0;
         data_wdata <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_access) begin
                  // The data_* registers double as the holding registers for the access.
                  r_state    <= S_REQ;
                  r_cnt      <= '0;
                  r_is_read  <= ~w_store;
                  data_req   <= 1'b1;
                  data_wr    <= w_store;
                  data_wstrb <= memwriteM;
                  data_addr  <= aluoutM;
                  data_wdata <= writedataM;
               end else begin
                  r_state <= S_IDLE;
               end
            end
            S_REQ: begin
               r_cnt <= w_cnt_inc;
               // Leaving REQ for any reason returns the bus outputs to zero.
               if (data_addr_ok || w_cnt_hit) begin
                  data_req   <= 1'b0;
                  data_wr    <= 1'b0;
                  data_wstrb <= 4'd0;
                  data_addr  <= 32'd0;
                  data_wdata <= 32'd0;
               end else begin
                  data_req <= 1'b1;
               end
               // data_ok without addr_ok is not a completion and is ignored here.
               if (data_addr_ok && data_data_ok) begin
                  r_state <= S_DONE;
                  if (r_is_read) begin
                     readdataM <= data_rdata;
                  end else begin
                     readdataM <= readdataM;
                  end
               end else if (w_cnt_hit) begin
                  r_state <= S_DONE;
                  bus_err <= 1'b1;
                  if (r_is_read) begin
                     readdataM <= 32'd0;
                  end else begin
                     readdataM <= readdataM;
                  end
               end else if (data_addr_ok) begin
                  r_state <= S_WAIT;
               end else begin
                  r_state <= S_REQ;
               end
            end
            S_WAIT: begin
               r_cnt <= w_cnt_inc;
               if (data_data_ok) begin
                  r_state <= S_DONE;
                  if (r_is_read) begin
                     readdataM <= data_rdata;
                  end else begin
                     readdataM <= readdataM;
                  end
               end else if (w_cnt_hit) begin
                  r_state <= S_DONE;
                  bus_err <= 1'b1;
                  if (r_is_read) begin
                     readdataM <= 32'd0;
                  end else begin
                     readdataM <= readdataM;
                  end
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_DONE: begin
               // One-cycle release so the pipeline can advance; bus inputs are ignored.
               r_state <= S_IDLE;
            end
            default: begin
               r_state    <= S_IDLE;
               data_req   <= 1'b0;
               data_wr    <= 1'b0;
               data_wstrb <= 4'd0;
               data_addr  <= 32'd0;
               data_wdata <= 32'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_bridge.sv
// Testbench for dmem_bridge: a directed vector table, a reset-mid-access
// sequence and randomized accesses, all checked against a transaction-level
// model that derives cycle timing from the chosen bus delays.
module tb_dmem_bridge;

   localparam int MAXW = 4;

   logic        clk;
   logic        rst;
   logic        memreadM;
   logic [3:0]  memwriteM;
   logic [31:0] aluoutM;
   logic [31:0] writedataM;
   logic [31:0] readdataM;
   logic        stallM;
   logic        data_req;
   logic        data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_err;

   int checks = 0;
   int errors = 0;

   // Model state: last load value seen by the pipeline and sticky error.
   logic [31:0] m_rd;
   logic        m_err;

   typedef struct {
      logic        rd;
      logic [3:0]  ws;
      logic [31:0] addr;
      logic [31:0] wd;
      int          a;
      int          d;
      logic [31:0] rdata;
      int          exp_stall;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vec [9];

   dmem_bridge #(.MAX_WAIT(MAXW)) dut (
      .clk          (clk),
      .rst          (rst),
      .memreadM     (memreadM),
      .memwriteM    (memwriteM),
      .aluoutM      (aluoutM),
      .writedataM   (writedataM),
      .readdataM    (readdataM),
      .stallM       (stallM),
      .data_req     (data_req),
      .data_wr      (data_wr),
      .data_wstrb   (data_wstrb),
      .data_addr    (data_addr),
      .data_wdata   (data_wdata),
      .data_addr_ok (data_addr_ok),
      .data_data_ok (data_data_ok),
      .data_rdata   (data_rdata),
      .bus_err      (bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog: the bench must never hang.
   initial begin
      #1000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (step %0d) actual=%h required=%h", nm, tag, act, exp);
      end
   endtask

   // One access: cycle 0 is IDLE with the access presented, cycles 1..n_end are
   // REQ/WAIT, cycle n_end+1 is DONE. addr_ok comes in REQ cycle a, data_ok in cycle d.
   task automatic run_access(input logic rd, input logic [3:0] ws, input logic [31:0] addr,
                             input logic [31:0] wd, input int a, input int d,
                             input logic [31:0] rdata, output int stall_seen);
      int          n_end;
      int          req_last;
      logic        tmo;
      logic        store;
      logic [31:0] new_rd;
      logic        new_err;
      logic        in_req;
      store    = (ws != 4'd0);
      tmo      = (d > MAXW);
      n_end    = tmo ? MAXW : d;
      req_last = (a < n_end) ? a : n_end;
      new_rd   = store ? m_rd : (tmo ? 32'd0 : rdata);
      new_err  = m_err | tmo;
      stall_seen = 0;
      for (int k = 0; k <= n_end + 1; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            memreadM   = rd;
            memwriteM  = ws;
            aluoutM    = addr;
            writedataM = wd;
         end else if (k <= n_end) begin
            aluoutM    = $urandom;
            writedataM = $urandom;
         end else begin
            memreadM   = 1'($urandom);
            memwriteM  = 4'($urandom);
            aluoutM    = $urandom;
            writedataM = $urandom;
         end
         if (k >= 1 && k == a) data_addr_ok = 1'b1;
         else if (k > a && k <= n_end) data_addr_ok = 1'($urandom);
         else data_addr_ok = 1'b0;
         if (k == d) begin
            data_data_ok = 1'b1;
            data_rdata   = rdata;
         end else if (k == 0 || k < a || k == n_end + 1) begin
            data_data_ok = 1'($urandom);
            data_rdata   = $urandom;
         end else begin
            data_data_ok = 1'b0;
            data_rdata   = $urandom;
         end
         @(negedge clk);
         in_req = (k >= 1 && k <= req_last);
         if (stallM) stall_seen++;
         check("stallM",     k, 32'(stallM),     32'(k <= n_end));
         check("data_req",   k, 32'(data_req),   32'(in_req));
         check("data_wr",    k, 32'(data_wr),    32'(in_req & store));
         check("data_wstrb", k, 32'(data_wstrb), in_req ? 32'(ws) : 32'd0);
         check("data_addr",  k, data_addr,       in_req ? addr : 32'd0);
         check("data_wdata", k, data_wdata,      in_req ? wd : 32'd0);
         check("readdataM",  k, readdataM,       (k <= n_end) ? m_rd : new_rd);
         check("bus_err",    k, 32'(bus_err),    32'((k <= n_end) ? m_err : new_err));
      end
      m_rd  = new_rd;
      m_err = new_err;
   endtask

   // A cycle with no access presented; stray bus handshakes must be ignored.
   task automatic idle_cycle(input int tag);
      @(posedge clk);
      #1;
      memreadM     = 1'b0;
      memwriteM    = 4'd0;
      aluoutM      = $urandom;
      writedataM   = $urandom;
      data_addr_ok = 1'($urandom);
      data_data_ok = 1'($urandom);
      data_rdata   = $urandom;
      @(negedge clk);
      check("idle stallM",    tag, 32'(stallM),   32'd0);
      check("idle data_req",  tag, 32'(data_req), 32'd0);
      check("idle data_addr", tag, data_addr,     32'd0);
      check("idle readdataM", tag, readdataM,     m_rd);
      check("idle bus_err",   tag, 32'(bus_err),  32'(m_err));
   endtask

   initial begin
      int st;
      logic        rd;
      logic [3:0]  ws;
      int          a;
      int          d;

      vec[0] = '{1'b1, 4'b0000, 32'h0000_0010, 32'h0,          1, 1, 32'hDEAD_BEEF, 2, 32'hDEAD_BEEF, 1'b0};
      vec[1] = '{1'b0, 4'b0011, 32'h0000_0020, 32'h0000_ABCD,  4, 4, 32'h0,         5, 32'hDEAD_BEEF, 1'b0};
      vec[2] = '{1'b1, 4'b0000, 32'h0000_0044, 32'h0,          1, 4, 32'h1234_5678, 5, 32'h1234_5678, 1'b0};
      vec[3] = '{1'b1, 4'b0000, 32'h0000_0100, 32'h0,          2, 2, 32'hCAFE_F00D, 3, 32'hCAFE_F00D, 1'b0};
      vec[4] = '{1'b0, 4'b1111, 32'h0000_0104, 32'h55AA_55AA,  1, 3, 32'h0,         4, 32'hCAFE_F00D, 1'b0};
      vec[5] = '{1'b1, 4'b0000, 32'h0000_0200, 32'h0,          9, 9, 32'h7777_7777, 5, 32'h0000_0000, 1'b1};
      vec[6] = '{1'b0, 4'b1100, 32'h0000_0204, 32'h9999_0000,  2, 5, 32'h0,         5, 32'h0000_0000, 1'b1};
      vec[7] = '{1'b1, 4'b0000, 32'h0000_0300, 32'h0,          1, 1, 32'h0BAD_CAFE, 2, 32'h0BAD_CAFE, 1'b1};
      vec[8] = '{1'b1, 4'b1000, 32'h0000_0308, 32'hA500_0000,  1, 1, 32'h1111_1111, 2, 32'h0BAD_CAFE, 1'b1};

      rst          = 1'b0;
      memreadM     = 1'b0;
      memwriteM    = 4'd0;
      aluoutM      = 32'd0;
      writedataM   = 32'd0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      data_rdata   = 32'd0;
      m_rd         = 32'd0;
      m_err        = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset stallM",    0, 32'(stallM),     32'd0);
      check("reset data_req",  0, 32'(data_req),   32'd0);
      check("reset data_wr",   0, 32'(data_wr),    32'd0);
      check("reset data_wstrb",0, 32'(data_wstrb), 32'd0);
      check("reset data_addr", 0, data_addr,       32'd0);
      check("reset data_wdata",0, data_wdata,      32'd0);
      check("reset readdataM", 0, readdataM,       32'd0);
      check("reset bus_err",   0, 32'(bus_err),    32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      idle_cycle(0);

      // Directed vectors, applied back to back
      for (int i = 0; i < 9; i++) begin
         run_access(vec[i].rd, vec[i].ws, vec[i].addr, vec[i].wd, vec[i].a, vec[i].d, vec[i].rdata, st);
         check("vec stall cycles", i, 32'(st),        32'(vec[i].exp_stall));
         check("vec readdataM",    i, readdataM,      vec[i].exp_rd);
         check("vec bus_err",      i, 32'(bus_err),   32'(vec[i].exp_err));
      end

      // Reset while WAITing: everything clears at once, a late data_ok is ignored
      @(posedge clk);
      #1;
      memreadM = 1'b1; memwriteM = 4'd0; aluoutM = 32'h0000_0400;
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      @(posedge clk);
      #1;
      data_addr_ok = 1'b1;
      @(posedge clk);
      #1;
      data_addr_ok = 1'b0;
      @(negedge clk);
      check("mid wait stallM", 0, 32'(stallM), 32'd1);
      #1;
      memreadM = 1'b0;
      rst = 1'b0;
      #1;
      check("async rst stallM",    0, 32'(stallM),   32'd0);
      check("async rst data_req",  0, 32'(data_req), 32'd0);
      check("async rst readdataM", 0, readdataM,     32'd0);
      check("async rst bus_err",   0, 32'(bus_err),  32'd0);
      m_rd  = 32'd0;
      m_err = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      data_data_ok = 1'b1;
      data_rdata   = 32'hFFFF_0000;
      @(negedge clk);
      check("late data_ok readdataM", 0, readdataM,     32'd0);
      check("late data_ok stallM",    0, 32'(stallM),   32'd0);
      check("late data_ok data_req",  0, 32'(data_req), 32'd0);
      #1;
      data_data_ok = 1'b0;
      run_access(1'b1, 4'd0, 32'h0000_0500, 32'd0, 1, 2, 32'h0A0B_0C0D, st);
      check("post reset stall cycles", 0, 32'(st), 32'd3);

      // Randomized accesses with random bus delays, including timeouts
      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 2) == 0) idle_cycle(i);
         if ($urandom_range(0, 1) == 0) begin
            rd = 1'b1;
            ws = 4'd0;
         end else begin
            rd = 1'($urandom);
            ws = 4'($urandom_range(1, 15));
         end
         a = $urandom_range(1, 5);
         d = $urandom_range(a, 6);
         run_access(rd, ws, $urandom, $urandom, a, d, $urandom, st);
      end
      idle_cycle(999);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
